// File: rtl/uart_pkg.sv
// Shared UART definitions: protocol command codes, the packet framing states
// and the baud divisor helper.
package uart_pkg;

    localparam logic [7:0] CMD_SETIMG = 8'h53;
    localparam logic [7:0] CMD_GETIMG = 8'h43;
    localparam logic [7:0] CMD_RDSR   = 8'h52;
    localparam logic [7:0] CMD_RDCR   = 8'h45;
    localparam logic [7:0] CMD_WRCR   = 8'h47;
    localparam logic [7:0] CMD_ADDR   = 8'h41;
    localparam logic [7:0] CMD_RDDATA = 8'h56;
    localparam logic [7:0] CMD_WRDATA = 8'h4B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_CMD,
        ST_SEND_LEN,
        ST_LOAD,
        ST_SEND_DATA,
        ST_SEND_CHK,
        ST_DONE
    } tx_state_t;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int calc_div(input int clock, input int baud);
        return (clock + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Serializes one byte as start bit, 8 data bits, optional parity and one stop bit.
// byte_done/ready are high in the final stop-bit cycle so the next byte can follow with no gap.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int    CLOCK     = 50_000_000,
    parameter int    BAUD      = 115_200,
    parameter string PARITY    = "NO",
    parameter string FIRST_BIT = "LSB"
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       txd,
    output logic       ready,
    output logic       byte_done
);

    localparam int DIV        = calc_div(CLOCK, BAUD);
    localparam int CW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam bit HAS_PARITY = (PARITY != "NO");
    localparam int NBITS      = HAS_PARITY ? 11 : 10;
    localparam logic [CW-1:0] LAST_TICK = CW'(DIV - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(NBITS - 1);

    logic          active;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_idx;
    logic [9:0]    shift_reg;
    logic [7:0]    ordered;
    logic          parity_bit;
    logic [9:0]    frame;
    logic          last_tick;

    // Everything after the start bit, packed so it shifts out from bit 0.
    always_comb begin
        ordered = data;
        if (FIRST_BIT == "MSB") begin
            for (int i = 0; i < 8; i++) begin
                ordered[i] = data[7-i];
            end
        end
        parity_bit = (PARITY == "ODD") ? ~^data : ^data;
        frame      = HAS_PARITY ? {1'b1, parity_bit, ordered} : {2'b11, ordered};
    end

    assign last_tick = active && (baud_cnt == LAST_TICK) && (bit_idx == LAST_BIT);
    assign byte_done = last_tick;
    assign ready     = !active || last_tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active    <= 1'b0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '1;
            txd       <= 1'b1;
        end else if (load && ready) begin
            active    <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= frame;
            txd       <= 1'b0;
        end else if (active) begin
            if (baud_cnt == LAST_TICK) begin
                baud_cnt <= '0;
                if (bit_idx == LAST_BIT) begin
                    active <= 1'b0;
                    txd    <= 1'b1;
                end else begin
                    bit_idx   <= bit_idx + 4'd1;
                    txd       <= shift_reg[0];
                    shift_reg <= {1'b1, shift_reg[9:1]};
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/packet_transmitter.sv
// Frames one response packet (CMD, LEN, payload from buffer RAM, inverted checksum)
// and hands each byte to the byte serializer.
module packet_transmitter
    import uart_pkg::*;
#(
    parameter int    CLOCK     = 50_000_000,
    parameter int    BAUD      = 115_200,
    parameter string PARITY    = "NO",
    parameter string FIRST_BIT = "LSB",
    parameter int    NUMBER    = 256,
    localparam int   AW        = (NUMBER > 1) ? $clog2(NUMBER) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    cmd_tx,
    input  logic [7:0]    len_tx,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic          txd,
    output logic          busy,
    output logic          tx_done
);

    tx_state_t  state, next_state;
    logic [7:0] len_q;
    logic [7:0] checksum;
    logic [7:0] pay_cnt;
    logic       byte_load;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic       byte_done;
    logic       last_payload;
    logic [AW-1:0] next_addr;

    assign last_payload = (pay_cnt == len_q - 8'd1);
    assign next_addr    = (rd_addr == AW'(NUMBER - 1)) ? '0 : rd_addr + 1'b1;
    assign busy         = (state != ST_IDLE) && (state != ST_DONE);
    assign tx_done      = (state == ST_DONE);

    uart_tx_byte #(
        .CLOCK     (CLOCK),
        .BAUD      (BAUD),
        .PARITY    (PARITY),
        .FIRST_BIT (FIRST_BIT)
    ) u_byte (
        .clk       (clk),
        .reset     (reset),
        .load      (byte_load),
        .data      (byte_data),
        .txd       (txd),
        .ready     (byte_ready),
        .byte_done (byte_done)
    );

    // Each next byte is loaded in the final stop-bit cycle of the current one, keeping the line gapless.
    always_comb begin
        next_state = state;
        byte_load  = 1'b0;
        byte_data  = cmd_tx;
        case (state)
            ST_IDLE: begin
                if (start && byte_ready) begin
                    byte_load  = 1'b1;
                    next_state = ST_SEND_CMD;
                end
            end
            ST_SEND_CMD: begin
                if (byte_done) begin
                    byte_load  = 1'b1;
                    byte_data  = len_q;
                    next_state = ST_SEND_LEN;
                end
            end
            ST_SEND_LEN: begin
                if (byte_done) begin
                    if (len_q == 8'd0) begin
                        byte_load  = 1'b1;
                        byte_data  = ~checksum;
                        next_state = ST_SEND_CHK;
                    end else begin
                        next_state = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                byte_load  = 1'b1;
                byte_data  = rd_data;
                next_state = ST_SEND_DATA;
            end
            ST_SEND_DATA: begin
                if (byte_done) begin
                    if (last_payload) begin
                        byte_load  = 1'b1;
                        byte_data  = ~checksum;
                        next_state = ST_SEND_CHK;
                    end else begin
                        next_state = ST_LOAD;
                    end
                end
            end
            ST_SEND_CHK: begin
                if (byte_done) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // rd_addr advances when a byte is captured so the RAM output is ready by the next LOAD,
    // and stops at the last payload address instead of running one past it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            checksum <= '0;
            pay_cnt  <= '0;
            rd_addr  <= '0;
        end else begin
            state <= next_state;
            case (state)
                ST_IDLE: begin
                    if (start && byte_ready) begin
                        len_q    <= len_tx;
                        checksum <= cmd_tx;
                        pay_cnt  <= '0;
                        rd_addr  <= '0;
                    end
                end
                ST_SEND_CMD: begin
                    if (byte_done) begin
                        checksum <= checksum + len_q;
                    end
                end
                ST_SEND_LEN: begin
                    if (byte_done) begin
                        rd_addr <= '0;
                    end
                end
                ST_LOAD: begin
                    checksum <= checksum + rd_data;
                    if (!last_payload) begin
                        rd_addr <= next_addr;
                    end
                end
                ST_SEND_DATA: begin
                    if (byte_done) begin
                        pay_cnt <= pay_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_transmitter.sv
// Randomized bench for packet_transmitter: a line monitor decodes txd into bytes
// and compares them with a packet built from the command, length and buffer contents.
module tb_packet_transmitter;
    import uart_pkg::*;

    localparam int CLOCK     = 50_000_000;
    localparam int MAIN_BAUD = 6_250_000;
    localparam int MAIN_DIV  = 8;
    localparam int OPT_BAUD  = 115_200;
    localparam int OPT_DIV   = 434;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] cmd_tx = 8'h00;
    logic [7:0] len_tx = 8'h00;
    logic [7:0] rd_addr;
    logic [7:0] rd_data = 8'h00;
    logic       txd, busy, tx_done;

    logic       opt_start = 1'b0;
    logic [7:0] opt_cmd = 8'h00;
    logic [7:0] opt_len = 8'h00;
    logic [7:0] opt_rd_data = 8'h00;
    logic [7:0] even_rd_addr, odd_rd_addr;
    logic       even_txd, even_busy, even_done;
    logic       odd_txd, odd_busy, odd_done;

    logic [7:0] mem [256];
    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] cmds [8] = '{CMD_SETIMG, CMD_GETIMG, CMD_RDSR, CMD_RDCR,
                             CMD_WRCR, CMD_ADDR, CMD_RDDATA, CMD_WRDATA};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    packet_transmitter #(
        .CLOCK(CLOCK), .BAUD(MAIN_BAUD), .PARITY("NO"), .FIRST_BIT("LSB"), .NUMBER(256)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cmd_tx(cmd_tx), .len_tx(len_tx),
        .rd_addr(rd_addr), .rd_data(rd_data), .txd(txd), .busy(busy), .tx_done(tx_done)
    );

    packet_transmitter #(
        .CLOCK(CLOCK), .BAUD(OPT_BAUD), .PARITY("EVEN"), .FIRST_BIT("MSB"), .NUMBER(256)
    ) dut_even (
        .clk(clk), .reset(reset), .start(opt_start), .cmd_tx(opt_cmd), .len_tx(opt_len),
        .rd_addr(even_rd_addr), .rd_data(opt_rd_data), .txd(even_txd), .busy(even_busy),
        .tx_done(even_done)
    );

    packet_transmitter #(
        .CLOCK(CLOCK), .BAUD(OPT_BAUD), .PARITY("ODD"), .FIRST_BIT("MSB"), .NUMBER(256)
    ) dut_odd (
        .clk(clk), .reset(reset), .start(opt_start), .cmd_tx(opt_cmd), .len_tx(opt_len),
        .rd_addr(odd_rd_addr), .rd_data(opt_rd_data), .txd(odd_txd), .busy(odd_busy),
        .tx_done(odd_done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference packet: CMD, LEN, payload, then the inverted mod-256 sum.
    task automatic buildExpected(input logic [7:0] cmd, input logic [7:0] len);
        int sum;
        exp_q.delete();
        exp_q.push_back(cmd);
        exp_q.push_back(len);
        sum = int'(cmd) + int'(len);
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back(mem[i]);
            sum += int'(mem[i]);
        end
        exp_q.push_back(8'(255 - (sum % 256)));
    endtask

    // Line monitor for the main DUT: 8N1, LSB first, sampled mid-bit.
    initial begin : line_monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (reset && txd === 1'b0) begin
                repeat (MAIN_DIV / 2) @(negedge clk);
                checkOutput("start_bit", txd, 1'b0);
                for (int k = 0; k < 8; k++) begin
                    repeat (MAIN_DIV) @(negedge clk);
                    b[k] = txd;
                end
                repeat (MAIN_DIV) @(negedge clk);
                checkOutput("stop_bit", txd, 1'b1);
                rx_q.push_back(b);
            end
        end
    end

    // Sends one packet; poke>0 pulses start again that many cycles after the accepted start.
    task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] len, input int poke);
        int elapsed, budget, expect_time, max_addr;
        bit got;
        rx_q.delete();
        buildExpected(cmd, len);
        @(negedge clk);
        cmd_tx = cmd;
        len_tx = len;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cmd_tx = 8'($urandom);
        len_tx = 8'($urandom);
        elapsed = 1;
        checkOutput("busy_rise", busy, 1'b1);
        expect_time = (int'(len) + 3) * 10 * MAIN_DIV + int'(len);
        budget = expect_time + 50;
        got = 1'b0;
        max_addr = 0;
        while (!got && elapsed < budget) begin
            @(negedge clk);
            elapsed++;
            start = (poke > 0 && elapsed == poke);
            if (busy && int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
            if (tx_done) got = 1'b1;
        end
        start = 1'b0;
        checkOutput("done_seen", got, 1'b1);
        checkOutput("done_time", (elapsed >= expect_time - 1 && elapsed <= expect_time + 1), 1'b1);
        @(negedge clk);
        checkOutput("done_single", tx_done, 1'b0);
        checkOutput("busy_fall", busy, 1'b0);
        checkOutput("byte_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checkOutput($sformatf("byte%0d", i), rx_q[i], exp_q[i]);
        end
        if (len != 8'd0) checkOutput("max_rd_addr", max_addr, int'(len) - 1);
    endtask

    // Parity/MSB-first instances: bit values at mid-bit and exact bit boundaries.
    task automatic checkOptions(input logic [7:0] d);
        logic [10:0] even_bits, odd_bits, exp_even, exp_odd;
        bit fin;
        exp_even[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_even[1+i] = d[7-i];
        exp_even[10] = 1'b1;
        exp_odd = exp_even;
        exp_even[9] = ^d;
        exp_odd[9]  = ~^d;
        even_bits = '0;
        odd_bits  = '0;
        @(negedge clk);
        opt_cmd   = d;
        opt_len   = 8'd0;
        opt_start = 1'b1;
        for (int j = 1; j <= 11 * OPT_DIV; j++) begin
            @(negedge clk);
            opt_start = 1'b0;
            if (j == OPT_DIV) begin
                checkOutput("even_start_end", even_txd, 1'b0);
                checkOutput("odd_start_end", odd_txd, 1'b0);
            end
            if (j == OPT_DIV + 1) checkOutput("even_first_data", even_txd, exp_even[1]);
            if (j == 2 * OPT_DIV) checkOutput("even_bit1_end", even_txd, exp_even[1]);
            if (j == 2 * OPT_DIV + 1) checkOutput("even_bit2_begin", even_txd, exp_even[2]);
            if (j % OPT_DIV == OPT_DIV / 2) begin
                even_bits[j / OPT_DIV] = even_txd;
                odd_bits[j / OPT_DIV]  = odd_txd;
            end
        end
        checkOutput("even_frame", even_bits, exp_even);
        checkOutput("odd_frame", odd_bits, exp_odd);
        checkOutput("even_parity", even_bits[9], exp_even[9]);
        checkOutput("odd_parity", odd_bits[9], exp_odd[9]);
        fin = 1'b0;
        for (int j = 0; j < 25 * OPT_DIV && !fin; j++) begin
            @(negedge clk);
            if (!even_busy && !odd_busy) fin = 1'b1;
        end
        checkOutput("opt_finished", fin, 1'b1);
    endtask

    // Reset during the second payload byte abandons the packet without tx_done.
    task automatic checkResetAbort();
        bit saw_done;
        for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
        @(negedge clk);
        cmd_tx = CMD_RDDATA;
        len_tx = 8'd4;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (31 * MAIN_DIV) @(negedge clk);
        checkOutput("abort_busy_before", busy, 1'b1);
        reset = 1'b0;
        #1;
        checkOutput("abort_txd", txd, 1'b1);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_done", tx_done, 1'b0);
        checkOutput("abort_rd_addr", rd_addr, 8'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        saw_done = 1'b0;
        repeat (40 * MAIN_DIV) begin
            @(negedge clk);
            if (tx_done) saw_done = 1'b1;
        end
        checkOutput("abort_no_done", saw_done, 1'b0);
        checkOutput("abort_idle_txd", txd, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        checkOutput("reset_txd", txd, 1'b1);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", tx_done, 1'b0);
        checkOutput("reset_rd_addr", rd_addr, 8'd0);
        checkOutput("reset_opt_txd", even_txd, 1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus(CMD_RDSR, 8'd0, 0);
        if (rx_q.size() == 3) checkOutput("min_chk", rx_q[2], 8'hAD);

        mem[0] = 8'hA5;
        mem[1] = 8'h3C;
        applyStimulus(CMD_RDDATA, 8'd2, 0);
        if (rx_q.size() == 5) checkOutput("two_byte_chk", rx_q[4], 8'hC6);

        applyStimulus(CMD_WRCR, 8'd3, 15 * MAIN_DIV);

        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
            applyStimulus(cmds[$urandom_range(0, 7)], 8'($urandom_range(0, 8)), 0);
        end

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        applyStimulus(CMD_RDDATA, 8'd255, 0);

        checkOptions(8'h81);

        checkResetAbort();
        for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
        applyStimulus(CMD_GETIMG, 8'd5, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/packet_transmitter.md
Name: packet_transmitter

Overview:
- Frames and serializes one response packet on the UART line.
- Packet format: CMD, LEN, LEN payload bytes read from a buffer RAM, CHK = ~(CMD+LEN+sum of payload) mod 256.
- This is the transmit-side counterpart of Receiver. It drives txd_uart in Top, and its output is decoded by Receiver in benches.

Parameters:
- CLOCK, 50_000_000, system clock frequency in Hz.
- BAUD, 115_200, line rate in bit/s. Bit period DIV = CLOCK/BAUD, integer, rounded to nearest.
- PARITY, "NO", "NO" / "ODD" / "EVEN".
- FIRST_BIT, "LSB", "LSB" / "MSB" serialization order.
- NUMBER, 256, payload buffer depth. rd_addr width = $clog2(NUMBER).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to send a packet. Sampled only in IDLE.
- cmd_tx  in  8  command byte. Latched on accepted start.
- len_tx  in  8  payload byte count. Latched on accepted start. 0 means no payload.
- rd_addr  out  $clog2(NUMBER)  payload buffer read address.
- rd_data  in  8  payload buffer data. Synchronous RAM, valid 1 cycle after rd_addr.
- txd  out  1  serial output. Idle high.
- busy  out  1  high from accepted start until tx_done.
- tx_done  out  1  one-cycle pulse after the CHK stop bit completes.

Behaviour:
- Reset values (asynchronous, reset low): txd=1, busy=0, tx_done=0, rd_addr=0, FSM=IDLE, checksum accumulator=0, all counters=0.
- FSM states: IDLE -> SEND_CMD -> SEND_LEN -> (LOAD -> SEND_DATA)×LEN -> SEND_CHK -> DONE -> IDLE.
- IDLE:
  - On start=1: latch cmd_tx and len_tx, busy=1, set checksum to cmd_tx, go to SEND_CMD.
  - The first start bit appears on txd the cycle after start.
- SEND_LEN: add len to checksum. On byte completion:
  - len=0 -> SEND_CHK.
  - otherwise rd_addr=0 -> LOAD.
- LOAD: wait one cycle for rd_data, capture it into the shift register, add it to checksum, go to SEND_DATA.
- SEND_DATA: on byte completion, increment payload counter and rd_addr.
  - Counter==len -> SEND_CHK.
  - otherwise -> LOAD.
- rd_addr wraps modulo NUMBER. With len up to 255 and NUMBER=256 no wrap occurs.
- SEND_CHK: transmit ~checksum.
- DONE: tx_done=1 for exactly one cycle, busy=0, go to IDLE.
- Checksum arithmetic is 8-bit modulo 256. Carries are discarded.
- Byte framing:
  - Start bit (0), then 8 data bits in FIRST_BIT order.
  - Optional parity bit: ODD = ~^data, EVEN = ^data.
  - One stop bit (1).
  - Every bit holds for exactly DIV clocks.
  - No idle gap between bytes, except the single LOAD cycle before each payload byte. The stop bit is extended by that one cycle.
- Packet duration:
  - Bits per byte = 10 (PARITY="NO") or 11 (with parity).
  - Packet time = (LEN+3) × bits per byte × DIV clocks, plus LEN extra LOAD cycles.
- start while busy: ignored, no queuing.
- start in the same cycle as tx_done: ignored. The new request is accepted in IDLE on the next cycle.
- Reset low mid-packet: txd returns to 1 immediately and the packet is abandoned. No tx_done is issued.
- cmd_tx/len_tx changes while busy have no effect.

Decomposition:
- Shared package (uart_pkg):
  - Command codes: SETIMG 0x53, GETIMG 0x43, RDSR 0x52, RDCR 0x45, WRCR 0x47, ADDR 0x41, RDDATA 0x56, WRDATA 0x4B.
  - FSM state enum.
  - Function calc_div(CLOCK, BAUD).
- Sub-module uart_tx_byte:
  - Parameters CLOCK, BAUD, PARITY, FIRST_BIT.
  - Ports clk, reset, load, data[7:0], txd, ready, byte_done.
  - Owns the baud counter and shift register.
  - packet_transmitter contains only the framing FSM, checksum, and address counter.

Test Plan:
- Settings CLOCK=50e6, BAUD=115200, DIV=434 unless stated.
- Minimal packet: start with cmd=0x52, len=0.
  - Required: txd bytes 0x52, 0x00, 0xAD.
  - tx_done pulses once, 30×434 clocks after start, ±1.
  - busy is low afterwards.
- Two-byte payload: RAM[0]=0xA5, RAM[1]=0x3C; start with cmd=0x56, len=2.
  - Required: bytes 0x56, 0x02, 0xA5, 0x3C, 0xC6.
  - rd_addr sequence 0, 1.
  - Looped back through Receiver: cmd_rx=0x56, len_rx=2, rx_done pulses.
- Full payload: RAM random, start with cmd=0x56, len=255.
  - Required: 258 bytes, CHK matches the model.
  - No rd_addr beyond 254.
- Options: PARITY="EVEN", FIRST_BIT="MSB", data 0x81.
  - Required: data bits appear MSB first, parity bit = 0.
  - Each bit measures 434 clocks.
  - Repeat with PARITY="ODD": parity bit = 1.
- Robustness:
  - start pulsed during the LEN byte -> ignored, packet unchanged.
  - reset asserted during payload byte 1 -> txd=1 next sample, busy=0, no tx_done.
  - A fresh start after release sends a correct complete packet.
